dcache_dm_refill: RTL and testbench
===================================

// Module: dcache_dm_refill
// PURPOSE
//  Parametrised direct-mapped, write-through, no-write-allocate data cache between the LSU and data memory.
//  Lookup is registered: hit data returns 1 cycle after request acceptance.
//  A read miss runs a multi-beat block refill over a valid/ready memory port, then returns the requested word.
//  Sits in the MEM stage; replaces the fixed 4-set, 4-word, no-reset cache.
// PARAMETERS
//  ADDR_WIDTH       32  byte address width
//  SETS             4   number of lines (power of 2, >=2)
//  WORDS_PER_BLOCK  4   32-bit words per line (power of 2, >=2)
//  Derived: WOFF=log2(WORDS_PER_BLOCK), IDX=log2(SETS), TAG=ADDR_WIDTH-2-WOFF-IDX. Data width fixed at 32.
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  cpu_req_valid  in   1   CPU request present
//  cpu_req_ready  out  1   cache accepts request (high only in IDLE)
//  cpu_we         in   1   1=store, 0=load
//  cpu_byte       in   1   1=byte access at lane addr[1:0], 0=word
//  cpu_addr       in   AW  byte address
//  cpu_wdata      in   32  store data (byte in [7:0] when cpu_byte)
//  cpu_rsp_valid  out  1   1-cycle pulse: load data valid / store complete
//  cpu_rdata      out  32  load data; byte loads zero-extended
//  mem_req_valid  out  1   memory request; held until mem_req_ready
//  mem_req_ready  in   1   memory accepts request
//  mem_we         out  1   1=write-through, 0=refill read
//  mem_addr       out  AW  word-aligned address
//  mem_be         out  4   byte enables (writes only; 4'hF on reads)
//  mem_wdata      out  32  write data, lane-aligned
//  mem_rsp_valid  in   1   read data beat valid
//  mem_rdata      in   32  read data
// BEHAVIOUR
//  Storage: per line valid bit, TAG-bit tag, WORDS_PER_BLOCK x 32 data.
//  Reset: all valid=0, FSM=IDLE; cpu_req_ready=1, every other output 0. Data/tag RAM not reset.
//  Request accepted on cpu_req_valid&&cpu_req_ready; addr/we/byte/wdata are registered.
//  FSM:
//   IDLE   -> LOOKUP on accept.
//   LOOKUP -> load hit: rsp_valid=1, rdata=selected word/byte, back to IDLE (latency 1 cycle).
//          -> load miss: REFILL, beat=0.
//          -> store: on hit, merge byte/word into line this cycle; go to WRITE (miss: no allocate).
//   REFILL -> one outstanding read at a time: drive mem_req (addr={tag,idx,beat,2'b00}); after ready, wait
//             mem_rsp_valid; write beat into line; beat++.
//             After beat WORDS_PER_BLOCK-1: set valid, load tag, go to RESPOND.
//   RESPOND -> rsp_valid=1 with requested word from line; IDLE.
//   WRITE  -> mem_req_valid=1, mem_we=1, be=byte?(1<<addr[1:0]):4'hF, wdata lane-shifted;
//             on mem_req_ready: rsp_valid=1, IDLE.
//  Refill order always word 0..N-1 (block-aligned, no wrap-around).
//  Valid is cleared at refill start and set only at the last beat, so a partial line is never hit.
//  mem_rsp_valid outside REFILL-wait is ignored. mem_req fields stable while valid && !ready.
//  mem_req_ready and mem_rsp_valid in the same cycle in REFILL: ready counts for the current beat's request;
//  the rsp is taken only in the wait phase.
//  rst_n low mid-refill/write: immediate abort to IDLE, all valid=0, mem_req_valid=0.
//  Beats/responses arriving after reset are ignored.
// CONFIGURATION
//  DCACHE_PERF_EN defined: adds outputs perf_hits[31:0] and perf_misses[31:0].
//   They count load hits in LOOKUP and load misses entering REFILL; they wrap at 2^32 and reset to 0.
//   Stores are not counted.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset, load 0x40 -> miss; 4 read beats at 0x40,0x44,0x48,0x4C with data 11,22,33,44;
//    rsp rdata=0x11 one cycle after beat 4; reload 0x48 -> rdata=0x33 1 cycle after accept, no mem_req.
//  2 After 1, byte load 0x49 with word 0xAABBCCDD -> rdata=0x000000CC.
//    Byte store 0x4A data 0x5E -> mem_be=4'b0100, mem_wdata=0x005E0000; reload 0x48 -> 0xAA5ECCDD.
//  3 Conflict: load 0x40 then 0x80 (same idx, SETS=4/WPB=4) -> second misses and refills;
//    reload 0x40 misses again.
//  4 Store miss 0x100 -> one mem write, no refill; following load 0x100 misses.
//  5 Stall mem_req_ready low 5 cycles mid-refill -> mem_addr/mem_req_valid stable.
//    Assert rst_n at beat 2 -> IDLE, load to same line misses.
//  6 With DCACHE_PERF_EN: scenario 1 -> perf_misses=1, perf_hits=1.

Source files
------------

// File: rtl/dcache_dm_refill_if.sv
// CPU-side and memory-side handshake bundle for dcache_dm_refill.
// The slave modport is the cache's view; master is the LSU/memory environment driving it.
interface dcache_dm_refill_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  cpu_req_valid;
   logic                  cpu_req_ready;
   logic                  cpu_we;
   logic                  cpu_byte;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [31:0]           cpu_wdata;
   logic                  cpu_rsp_valid;
   logic [31:0]           cpu_rdata;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wdata;
   logic                  mem_rsp_valid;
   logic [31:0]           mem_rdata;

   modport slave (
      input  cpu_req_valid, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rdata,
      output cpu_req_ready, cpu_rsp_valid, cpu_rdata,
      output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output cpu_req_valid, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rdata,
      input  cpu_req_ready, cpu_rsp_valid, cpu_rdata,
      input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/dcache_dm_refill.sv
// Direct-mapped, write-through, no-write-allocate data cache with multi-beat block refill.
// Define DCACHE_PERF_EN to add the perf_hits / perf_misses load counters.
module dcache_dm_refill #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned SETS            = 4,
   parameter int unsigned WORDS_PER_BLOCK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef DCACHE_PERF_EN
   output logic [31:0]        perf_hits,
   output logic [31:0]        perf_misses,
`endif
   dcache_dm_refill_if.slave  bus
);
   localparam int unsigned WOFF = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned IDX  = $clog2(SETS);
   localparam int unsigned TAG  = ADDR_WIDTH - 2 - WOFF - IDX;

   typedef enum logic [2:0] {StIdle, StLookup, StRefill, StRespond, StWrite} state_e;

   state_e                state_q, state_d;
   logic [WOFF-1:0]       beat_q, beat_d;
   logic                  wait_q, wait_d;   // refill beat: request accepted, awaiting data
   logic [SETS-1:0]       valid_q;
   logic [TAG-1:0]        tag_q  [SETS];
   logic [31:0]           data_q [SETS][WORDS_PER_BLOCK];

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q, byte_q;
   logic [31:0]           wdata_q;

   logic [IDX-1:0]        idx;
   logic [WOFF-1:0]       woff;
   logic [TAG-1:0]        tag;
   logic [4:0]            shamt;
   logic [31:0]           line_word, load_data, store_word, lane_wdata;
   logic [3:0]            lane_be;
   logic                  hit, last_beat;
   logic                  refill_we, merge_we, clr_valid, set_valid;

   logic                  req_ready, rsp_valid, mreq_valid, mreq_we;
   logic [31:0]           rdata, mreq_wdata;
   logic [ADDR_WIDTH-1:0] mreq_addr;
   logic [3:0]            mreq_be;

   assign idx        = addr_q[2+WOFF +: IDX];
   assign woff       = addr_q[2 +: WOFF];
   assign tag        = addr_q[ADDR_WIDTH-1 -: TAG];
   assign shamt      = {addr_q[1:0], 3'b000};
   assign line_word  = data_q[idx][woff];
   assign hit        = valid_q[idx] && (tag_q[idx] == tag);
   assign last_beat  = (beat_q == WOFF'(WORDS_PER_BLOCK - 1));
   assign load_data  = byte_q ? {24'b0, 8'(line_word >> shamt)} : line_word;
   assign lane_wdata = byte_q ? (32'(wdata_q[7:0]) << shamt) : wdata_q;
   assign lane_be    = byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
   assign store_word = byte_q ? ((line_word & ~(32'hFF << shamt)) | lane_wdata) : wdata_q;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      wait_d     = wait_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rdata      = '0;
      mreq_valid = 1'b0;
      mreq_we    = 1'b0;
      mreq_addr  = '0;
      mreq_be    = '0;
      mreq_wdata = '0;
      refill_we  = 1'b0;
      merge_we   = 1'b0;
      clr_valid  = 1'b0;
      set_valid  = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (bus.cpu_req_valid) state_d = StLookup;
         end
         StLookup: begin
            if (we_q) begin
               merge_we = hit;
               state_d  = StWrite;
            end else if (hit) begin
               rsp_valid = 1'b1;
               rdata     = load_data;
               state_d   = StIdle;
            end else begin
               // Line is invalidated up front so a partially refilled block never hits.
               clr_valid = 1'b1;
               beat_d    = '0;
               wait_d    = 1'b0;
               state_d   = StRefill;
            end
         end
         StRefill: begin
            if (!wait_q) begin
               mreq_valid = 1'b1;
               mreq_addr  = {tag, idx, beat_q, 2'b00};
               mreq_be    = 4'hF;
               if (bus.mem_req_ready) wait_d = 1'b1;
            end else if (bus.mem_rsp_valid) begin
               refill_we = 1'b1;
               wait_d    = 1'b0;
               beat_d    = beat_q + WOFF'(1);
               if (last_beat) begin
                  set_valid = 1'b1;
                  state_d   = StRespond;
               end
            end
         end
         StRespond: begin
            rsp_valid = 1'b1;
            rdata     = load_data;
            state_d   = StIdle;
         end
         StWrite: begin
            mreq_valid = 1'b1;
            mreq_we    = 1'b1;
            mreq_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            mreq_be    = lane_be;
            mreq_wdata = lane_wdata;
            if (bus.mem_req_ready) begin
               rsp_valid = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         beat_q  <= '0;
         wait_q  <= 1'b0;
         valid_q <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         wait_q  <= wait_d;
         if (clr_valid) valid_q[idx] <= 1'b0;
         if (set_valid) valid_q[idx] <= 1'b1;
         if (state_q == StIdle && bus.cpu_req_valid) begin
            addr_q  <= bus.cpu_addr;
            we_q    <= bus.cpu_we;
            byte_q  <= bus.cpu_byte;
            wdata_q <= bus.cpu_wdata;
         end
      end
   end

   // Tag and data arrays are qualified by valid_q and need no reset.
   always_ff @(posedge clk) begin
      if (refill_we) data_q[idx][beat_q] <= bus.mem_rdata;
      if (merge_we)  data_q[idx][woff]   <= store_word;
      if (set_valid) tag_q[idx]          <= tag;
   end

`ifdef DCACHE_PERF_EN
   logic [31:0] hits_q, misses_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (state_q == StLookup && !we_q) begin
         if (hit) hits_q   <= hits_q + 32'd1;
         else     misses_q <= misses_q + 32'd1;
      end
   end

   assign perf_hits   = hits_q;
   assign perf_misses = misses_q;
`endif

   assign bus.cpu_req_ready = req_ready;
   assign bus.cpu_rsp_valid = rsp_valid;
   assign bus.cpu_rdata     = rdata;
   assign bus.mem_req_valid = mreq_valid;
   assign bus.mem_we        = mreq_we;
   assign bus.mem_addr      = mreq_addr;
   assign bus.mem_be        = mreq_be;
   assign bus.mem_wdata     = mreq_wdata;
endmodule

// File: tb/tb_dcache_dm_refill.sv
// Scoreboard bench for dcache_dm_refill: expected CPU responses and memory requests are queued
// by the stimulus, then popped and compared by independent monitor / memory responder processes.
module tb_dcache_dm_refill;
   localparam int unsigned AW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_dm_refill_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef DCACHE_PERF_EN
   logic [31:0] perf_hits, perf_misses;
`endif

   dcache_dm_refill #(
      .ADDR_WIDTH(AW),
      .SETS(4),
      .WORDS_PER_BLOCK(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef DCACHE_PERF_EN
      .perf_hits(perf_hits),
      .perf_misses(perf_misses),
`endif
      .bus(bus)
   );

   typedef struct {
      logic        is_load;
      logic [31:0] rdata;
      int          lat;     // 0: unchecked, 1: after accept, 2: after last refill beat
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mreq_t;

   rsp_t        exp_rsp[$];
   mreq_t       exp_mem[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   int unsigned accept_cyc = 0;
   int unsigned last_beat_cyc = 0;
   logic [31:0] mem_model [256];
   logic [31:0] stall_addr = 32'hFFFF_FFFF;
   int          stall_n = 0;
   logic [31:0] stop_addr = 32'hFFFF_FFFF;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   function automatic void fail(input string name, input logic [31:0] info);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h, nothing was expected here", name, info);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // CPU response monitor
   always @(negedge clk) begin
      if (rst_n && bus.cpu_rsp_valid) begin
         if (exp_rsp.size() == 0) begin
            fail("unexpected_cpu_rsp", bus.cpu_rdata);
         end else begin
            rsp_t e;
            e = exp_rsp.pop_front();
            if (e.is_load) chk("rsp_rdata", bus.cpu_rdata, e.rdata);
            if (e.lat == 1) chk("hit_latency", 32'(cyc - accept_cyc), 32'd1);
            if (e.lat == 2) chk("refill_rsp_latency", 32'(cyc - last_beat_cyc), 32'd1);
         end
      end
   end

   // Memory responder: checks each request against the queue, optional stall, then one beat.
   initial begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = '0;
      forever begin
         tick();
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b0;
         if (rst_n && bus.mem_req_valid && bus.mem_addr != stop_addr) begin
            mreq_t got, e;
            got = '{bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
            if (exp_mem.size() == 0) begin
               fail("unexpected_mem_req", got.addr);
            end else begin
               e = exp_mem.pop_front();
               chk("mem_we", {31'b0, got.we}, {31'b0, e.we});
               chk("mem_addr", got.addr, e.addr);
               chk("mem_be", {28'b0, got.be}, {28'b0, e.be});
               if (e.we) chk("mem_wdata", got.wdata, e.wdata);
            end
            if (got.addr == stall_addr) begin
               repeat (stall_n) begin
                  tick();
                  chk("stall_req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
                  chk("stall_req_addr", bus.mem_addr, got.addr);
               end
            end
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            if (!got.we) begin
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rdata     = mem_model[got.addr[9:2]];
               last_beat_cyc     = cyc;
            end else begin
               for (int b = 0; b < 4; b++)
                  if (got.be[b]) mem_model[got.addr[9:2]][8*b +: 8] = got.wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic issue(input logic we, input logic byte_en, input logic [31:0] addr,
                        input logic [31:0] wdata);
      int n;
      tick();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_we        = we;
      bus.cpu_byte      = byte_en;
      bus.cpu_addr      = addr;
      bus.cpu_wdata     = wdata;
      n = 0;
      while (!bus.cpu_req_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.cpu_req_ready) fail("req_ready_timeout", addr);
      accept_cyc = cyc;
      tick();
      bus.cpu_req_valid = 1'b0;
   endtask

   task automatic push_block(input logic [31:0] base);
      for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b0, base + 32'(4 * i), 4'hF, 32'h0});
   endtask

   task automatic load(input logic [31:0] addr, input logic byte_en, input logic miss,
                       input logic [31:0] exp_data);
      if (miss) push_block({addr[31:4], 4'h0});
      exp_rsp.push_back('{1'b1, exp_data, miss ? 2 : 1});
      issue(1'b0, byte_en, addr, 32'h0);
   endtask

   task automatic store(input logic [31:0] addr, input logic byte_en, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] lane_data);
      exp_mem.push_back('{1'b1, {addr[31:2], 2'b00}, be, lane_data});
      exp_rsp.push_back('{1'b0, 32'h0, 0});
      issue(1'b1, byte_en, addr, wdata);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || exp_mem.size() != 0) && n < 500) begin
         tick();
         n++;
      end
      if (exp_rsp.size() != 0 || exp_mem.size() != 0) begin
         fail(name, 32'(exp_rsp.size() + exp_mem.size()));
         exp_rsp.delete();
         exp_mem.delete();
      end
      repeat (2) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
      mem_model[8'h10] = 32'h11; mem_model[8'h11] = 32'h22;
      mem_model[8'h12] = 32'h33; mem_model[8'h13] = 32'h44;
      mem_model[8'h20] = 32'h55; mem_model[8'h21] = 32'h66;
      mem_model[8'h22] = 32'h77; mem_model[8'h23] = 32'h88;
      mem_model[8'h30] = 32'hC1; mem_model[8'h31] = 32'hC2;
      mem_model[8'h32] = 32'hC3; mem_model[8'h33] = 32'hC4;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_we        = 1'b0;
      bus.cpu_byte      = 1'b0;
      bus.cpu_addr      = '0;
      bus.cpu_wdata     = '0;

      repeat (3) tick();
      chk("rst_req_ready", {31'b0, bus.cpu_req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, bus.cpu_rsp_valid}, 32'd0);
      chk("rst_rdata", bus.cpu_rdata, 32'd0);
      chk("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
      chk("rst_mem_we_be", {27'b0, bus.mem_we, bus.mem_be}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      rst_n = 1'b1;

      // Cold miss with 4-beat refill, then a hit in the same line
      load(32'h40, 1'b0, 1'b1, 32'h11); drain("s1_miss");
      load(32'h48, 1'b0, 1'b0, 32'h33); drain("s1_hit");
`ifdef DCACHE_PERF_EN
      chk("perf_misses", perf_misses, 32'd1);
      chk("perf_hits", perf_hits, 32'd1);
`endif

      // Store hits merge into the line and write through
      store(32'h48, 1'b0, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD); drain("s2_word_store");
      load(32'h49, 1'b1, 1'b0, 32'h000000CC); drain("s2_byte_load");
      store(32'h4A, 1'b1, 32'h0000005E, 4'b0100, 32'h005E0000); drain("s2_byte_store");
      load(32'h48, 1'b0, 1'b0, 32'hAA5ECCDD); drain("s2_merged");

      // Conflict eviction on index 0
      load(32'h40, 1'b0, 1'b0, 32'h11); drain("s3_hit");
      load(32'h80, 1'b0, 1'b1, 32'h55); drain("s3_conflict");
      load(32'h40, 1'b0, 1'b1, 32'h11); drain("s3_refetch");
      load(32'h48, 1'b0, 1'b0, 32'hAA5ECCDD); drain("s3_written_through");

      // Store miss: write only, no allocation
      store(32'h100, 1'b0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF); drain("s4_store_miss");
      load(32'h100, 1'b0, 1'b1, 32'hDEADBEEF); drain("s4_load_after");

      // Stalled beat 1, then reset while beat 2 is requested
      stall_addr = 32'hC4;
      stall_n    = 5;
      stop_addr  = 32'hC8;
      exp_mem.push_back('{1'b0, 32'hC0, 4'hF, 32'h0});
      exp_mem.push_back('{1'b0, 32'hC4, 4'hF, 32'h0});
      issue(1'b0, 1'b0, 32'hC0, 32'h0);
      n = 0;
      while (!(bus.mem_req_valid && bus.mem_addr == 32'hC8) && n < 100) begin
         tick();
         n++;
      end
      chk("s5_beat2_req", {31'b0, bus.mem_req_valid}, 32'd1);
      chk("s5_beats_done", 32'(exp_mem.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("s5_abort_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
      chk("s5_abort_ready", {31'b0, bus.cpu_req_ready}, 32'd1);
      tick();
      rst_n     = 1'b1;
      stop_addr = 32'hFFFF_FFFF;
      stall_n   = 0;
      load(32'hC0, 1'b0, 1'b1, 32'hC1); drain("s5_after_reset");
      load(32'hC8, 1'b0, 1'b0, 32'hC3); drain("s5_refilled_hit");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
